// File: rtl/fetch_stage_pkg.sv
// Shared core definitions for the fetch front end and the execute-stage
// branch condition generator: redirect codes, fetch FSM states, reset vector.
package fetch_stage_pkg;

  // Redirect code produced by the branch condition generator (6-7 reserved).
  typedef enum logic [2:0] {
    PC_SEQ    = 3'd0,
    PC_JALR   = 3'd1,
    PC_BRANCH = 3'd2,
    PC_JAL    = 3'd3,
    PC_MTVEC  = 3'd4,
    PC_MEPC   = 3'd5
  } pcsrc_t;

  // Fetch FSM: BOOT after reset, RUN while streaming, HOLD while a stalled
  // instruction is parked in the hold buffer.
  typedef enum logic [1:0] {
    FS_BOOT = 2'd0,
    FS_RUN  = 2'd1,
    FS_HOLD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP              = 32'h0000_0004;

endpackage

// File: rtl/fetch_stage_pc_next_mux.sv
// Combinational next-PC selection and FLUSH decode from the 3-bit redirect code.
// Reserved codes 6-7 fall back to sequential fetch and never flush.
module pc_next_mux
  import fetch_stage_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [2:0]  pc_source_i,
  input  logic [31:0] jalr_tgt_i,
  input  logic [31:0] branch_tgt_i,
  input  logic [31:0] jal_tgt_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  output logic [31:0] next_pc_o,
  output logic        flush_o
);

  // Select the next fetch address; any real redirect also squashes younger stages.
  always_comb begin
    next_pc_o = pc_i + PC_STEP;
    flush_o   = 1'b0;
    case (pcsrc_t'(pc_source_i))
      PC_JALR: begin
        next_pc_o = jalr_tgt_i & 32'hFFFF_FFFE;
        flush_o   = 1'b1;
      end
      PC_BRANCH: begin
        next_pc_o = branch_tgt_i;
        flush_o   = 1'b1;
      end
      PC_JAL: begin
        next_pc_o = jal_tgt_i;
        flush_o   = 1'b1;
      end
      PC_MTVEC: begin
        next_pc_o = mtvec_i;
        flush_o   = 1'b1;
      end
      PC_MEPC: begin
        next_pc_o = mepc_i;
        flush_o   = 1'b1;
      end
      default: begin
        next_pc_o = pc_i + PC_STEP;
        flush_o   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC register (F1) driving a synchronous
// instruction memory, F2 register tracking the returning instruction, a hold
// buffer for stalls, and redirect/squash handling.
// Optional feature: define FETCH_PERF_EN to build the delivered-instruction and
// redirect counters; otherwise FETCH_COUNT/SQUASH_COUNT are tied to zero.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [2:0]  PC_SOURCE,
  input  logic [31:0] JALR_TGT,
  input  logic [31:0] BRANCH_TGT,
  input  logic [31:0] JAL_TGT,
  input  logic [31:0] MTVEC,
  input  logic [31:0] MEPC,
  input  logic        STALL,
  output logic [31:0] IMEM_ADDR,
  input  logic [31:0] IMEM_RDATA,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_INSTR,
  output logic        IF_VALID,
  output logic        FLUSH,
  output logic [31:0] FETCH_COUNT,
  output logic [31:0] SQUASH_COUNT
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  f2_pc_q, f2_pc_d;
  logic         f2_valid_q, f2_valid_d;
  logic [31:0]  hold_q, hold_d;
  logic         hold_valid_q, hold_valid_d;

  logic [31:0]  next_pc;
  logic         redirect;
  logic         if_valid;

  pc_next_mux u_pc_next_mux (
    .pc_i         (pc_q),
    .pc_source_i  (PC_SOURCE),
    .jalr_tgt_i   (JALR_TGT),
    .branch_tgt_i (BRANCH_TGT),
    .jal_tgt_i    (JAL_TGT),
    .mtvec_i      (MTVEC),
    .mepc_i       (MEPC),
    .next_pc_o    (next_pc),
    .flush_o      (redirect)
  );

  // Next-state logic: redirect has priority over stall in every state.
  // Leaving HOLD advances F1/F2 on the same edge, because the instruction
  // presented from the hold buffer is delivered in that cycle.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    f2_pc_d      = f2_pc_q;
    f2_valid_d   = f2_valid_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    if (redirect) begin
      pc_d         = next_pc;
      f2_valid_d   = 1'b0;
      hold_valid_d = 1'b0;
      state_d      = FS_RUN;
    end else begin
      case (state_q)
        FS_BOOT: begin
          state_d = FS_RUN;
        end
        FS_RUN: begin
          if (!STALL) begin
            pc_d       = next_pc;
            f2_pc_d    = pc_q;
            f2_valid_d = 1'b1;
          end else if (f2_valid_q) begin
            // Memory will re-read the frozen PC next cycle; park the live word.
            hold_d       = IMEM_RDATA;
            hold_valid_d = 1'b1;
            state_d      = FS_HOLD;
          end else begin
            state_d = FS_RUN;
          end
        end
        FS_HOLD: begin
          if (!STALL) begin
            pc_d         = next_pc;
            f2_pc_d      = pc_q;
            f2_valid_d   = 1'b1;
            hold_valid_d = 1'b0;
            state_d      = FS_RUN;
          end else begin
            state_d = FS_HOLD;
          end
        end
        default: begin
          f2_valid_d   = 1'b0;
          hold_valid_d = 1'b0;
          state_d      = FS_BOOT;
        end
      endcase
    end
  end

  // Fetch state registers with asynchronous reset to the boot condition.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= FS_BOOT;
      pc_q         <= RESET_VECTOR;
      f2_pc_q      <= 32'h0000_0000;
      f2_valid_q   <= 1'b0;
      hold_q       <= 32'h0000_0000;
      hold_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      f2_pc_q      <= f2_pc_d;
      f2_valid_q   <= f2_valid_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
    end
  end

  assign if_valid  = f2_valid_q & ~redirect;
  assign IMEM_ADDR = pc_q;
  assign IF_PC     = f2_pc_q;
  assign IF_VALID  = if_valid;
  assign FLUSH     = redirect;
  assign IF_INSTR  = ((state_q == FS_HOLD) && hold_valid_q) ? hold_q : IMEM_RDATA;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] squash_cnt_q, squash_cnt_d;

  // Counter increments: delivered instructions and redirects, both wrapping.
  always_comb begin
    fetch_cnt_d  = fetch_cnt_q;
    squash_cnt_d = squash_cnt_q;
    if (if_valid && !STALL) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end else begin
      fetch_cnt_d = fetch_cnt_q;
    end
    if (redirect) begin
      squash_cnt_d = squash_cnt_q + 32'd1;
    end else begin
      squash_cnt_d = squash_cnt_q;
    end
  end

  // Performance counter registers, cleared by reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fetch_cnt_q  <= 32'h0000_0000;
      squash_cnt_q <= 32'h0000_0000;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end

  assign FETCH_COUNT  = fetch_cnt_q;
  assign SQUASH_COUNT = squash_cnt_q;
`else
  assign FETCH_COUNT  = 32'h0000_0000;
  assign SQUASH_COUNT = 32'h0000_0000;
`endif

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch front end of the pipelined core: owns the program counter, drives the synchronous instruction memory and presents fetched instructions to decode. It consumes the 3-bit `PC_SOURCE` redirect code produced by the execute-stage branch condition generator, plus the matching targets, and squashes wrong-path fetches on every redirect. Stall requests come from the hazard unit.

## Interface
- `RESET_VECTOR`, default 32'h0000_0000, PC value loaded on reset
- `CLK` input 1: sole clock, rising edge
- `RST` input 1: asynchronous, active-high reset
- `PC_SOURCE` input 3: redirect code from execute; 0 sequential, 1 JALR, 2 branch, 3 JAL, 4 MTVEC, 5 MEPC, 6–7 reserved
- `JALR_TGT` input 32: JALR target (bit 0 cleared internally)
- `BRANCH_TGT` input 32: conditional-branch target
- `JAL_TGT` input 32: JAL target
- `MTVEC` input 32: trap vector
- `MEPC` input 32: trap return address
- `STALL` input 1: hold fetch and decode-facing outputs
- `IMEM_ADDR` output 32: instruction memory address (= PC register)
- `IMEM_RDATA` input 32: memory data, valid the cycle after the address is sampled
- `IF_PC` output 32: PC of presented instruction
- `IF_INSTR` output 32: presented instruction
- `IF_VALID` output 1: presented instruction is live
- `FLUSH` output 1: squash younger stages (decode, execute)
- `FETCH_COUNT` output 32: delivered-instruction counter (see Configuration)
- `SQUASH_COUNT` output 32: redirect counter (see Configuration)

## Operation
- Two internal fetch steps: F1 = PC register (drives `IMEM_ADDR`); F2 = `f2_pc`, `f2_valid` (instruction returning from memory).
- Next PC: code 0 → PC+4; 1 → `JALR_TGT & ~1`; 2/3/4/5 → respective target; 6–7 → PC+4 (treated as sequential).
- `FLUSH` = combinational, high iff `PC_SOURCE` ∈ {1..5}.
- FSM states:
  - BOOT: entered on reset; PC=`RESET_VECTOR`, `f2_valid`=0; goes to RUN unconditionally next cycle.
  - RUN: on each edge without stall, PC←next PC, `f2_pc`←PC, `f2_valid`←1. If `STALL` and `f2_valid`, capture `IMEM_RDATA` into hold buffer and go to HOLD.
  - HOLD: PC, `f2_*` frozen; `IF_INSTR` from hold buffer. When `STALL` drops, go to RUN.
- Redirect beats stall: with `FLUSH` high in any state, PC←target, `f2_valid`←0, hold buffer invalidated, state←RUN.
- `IF_INSTR` = hold buffer if in HOLD, else `IMEM_RDATA`. `IF_PC`=`f2_pc`. `IF_VALID`=`f2_valid` & ~`FLUSH`.
- PC arithmetic is 32-bit modulo; PC+4 from 32'hFFFF_FFFC wraps to 0.
- No alignment check on targets; bits [1:0] are passed through unchanged (except JALR bit 0).

## Timing
- Reset values: PC=`RESET_VECTOR`, `IMEM_ADDR`=`RESET_VECTOR`, `f2_pc`=0, `IF_VALID`=0, hold buffer invalid, state=BOOT, both counters 0. `FLUSH` follows its input.
- First `IF_VALID` occurs 2 cycles after `RST` deasserts: BOOT cycle, then the RUN cycle.
- Redirect seen at edge n: `IMEM_ADDR`=target in n+1; target instruction has `IF_VALID`=1 in n+2; two wrong-path slots are squashed.
- Stall: outputs are frozen in the same cycle `STALL` is high. Fetch resumes on the first edge with `STALL`=0, with no lost or duplicated instruction.
- Reset mid-stall or mid-redirect: everything returns to reset values immediately (asynchronous).

## Configuration
- `FETCH_PERF_EN` defined:
  - `FETCH_COUNT` increments on every edge with `IF_VALID` & ~`STALL`.
  - `SQUASH_COUNT` increments on every edge with `FLUSH`.
  - Both are 32-bit, wrap silently, and clear on reset.
- `FETCH_PERF_EN` undefined: both ports are tied to 0, no counter flops exist, and the interface is unchanged.

## Structure
- Shared core package holds:
  - enum `pcsrc_t` (PC_SEQ=0, PC_JALR=1, PC_BRANCH=2, PC_JAL=3, PC_MTVEC=4, PC_MEPC=5), shared with the branch condition generator
  - fetch FSM state enum
  - default `RESET_VECTOR`
- One sub-module, `pc_next_mux`: purely combinational next-PC selection plus `FLUSH` decode.

## Test plan
- Reset release, memory returns 32'h0000_0013 at address 0 → `IF_VALID` rises 2 cycles later with `IF_PC`=0; then `IF_PC` takes 4, 8, … on consecutive cycles.
- `PC_SOURCE`=2, `BRANCH_TGT`=32'h100, issued at PC 0x20 → `FLUSH` high 1 cycle; `IMEM_ADDR`=0x100 next cycle; `IF_PC`=0x100 valid 2 cycles after; squashed PCs 0x1C/0x20 are never valid.
- `STALL` high 3 cycles while `IF_PC`=0x8 → `IF_PC`/`IF_INSTR` held at 0x8 and its instruction; after release, sequence continues with 0xC, with no skip and no repeat.
- `STALL` and `PC_SOURCE`=1 with `JALR_TGT`=32'h205 together → redirect wins; `IMEM_ADDR`=0x204; hold buffer discarded.
- `RST` pulsed during HOLD → `IF_VALID`=0 and PC=`RESET_VECTOR` immediately; `PC_SOURCE`=7 → treated as sequential with `FLUSH`=0.
- With `FETCH_PERF_EN`: 10 delivered instructions and 2 redirects → `FETCH_COUNT`=10, `SQUASH_COUNT`=2. Without the macro, both read 0.
